calc_entry_fsm: RTL and testbench
=================================

// Module: calc_entry_fsm
// PURPOSE
//  Keyboard-event consumer that sits directly downstream of the keypad scanner.
//  It turns the scanner's level flags (is_num/is_op/is_eq + num_val/op_val) into
//  operand A, an operator and operand B, then evaluates A op B in signed decimal.
//  It drives the value to display (magnitude + sign) for the 7-seg stage.
//  One event is taken per key press; division is iterative.
// PARAMETERS
//  DIGITS  4   max decimal digits per operand/result (|value| <= 10^DIGITS-1)
//  W       14  magnitude width; must satisfy 2^W > 10^DIGITS-1
// PORTS
//  clk          in   1   system clock (same domain as keypad scanner)
//  rst          in   1   async reset, ACTIVE-LOW
//  is_num       in   1   level, high while a digit key is held
//  is_op        in   1   level, high while an operator key is held
//  is_eq        in   1   level, high while '=' is held
//  num_val      in   4   digit value, valid while is_num
//  op_val       in   2   00 add, 01 sub, 10 mul, 11 div; valid while is_op
//  disp_val     out  W   magnitude to display
//  disp_neg     out  1   sign of disp_val (1 = negative)
//  err          out  1   high in ERR state (overflow or divide by zero)
//  busy         out  1   high while COMPUTE/DIV; key events are dropped
//  result_valid out  1   one-cycle pulse when a result is loaded to disp_val
//  state_dbg    out  3   current FSM state encoding
// BEHAVIOUR
//  - Reset (rst=0, async): state=ENTER_A, A=B=0, op=add, all outputs 0.
//  - Event: cycle E where (is_num|is_op|is_eq)=1 and the registered previous OR=0.
//    Priority when several flags are high at E: eq > op > num. Holding a key
//    gives exactly one event. Events during busy=1 are discarded (not queued).
//  - Digit accepted only if num_val<=9; otherwise ignored. Entry: v=v*10+d, and
//    only while fewer than DIGITS digits are entered (extra digits ignored).
//    disp_val shows the operand under entry from E+1.
//  - States and transitions:
//    ENTER_A : digit->A; op->latch op, OP_WAIT (display keeps A); eq->RESULT with
//              result=A, result_valid.
//    OP_WAIT : digit->B=d, ENTER_B; op->replace op; eq ignored.
//    ENTER_B : digit->B; eq->COMPUTE (div: DIV); op->ignored.
//    COMPUTE : one cycle, add/sub/mul in signed W+1 bits (mul in 2W+1), goes to
//              RESULT, or ERR if |res|>10^DIGITS-1.
//    DIV     : B==0 -> ERR next cycle. Else calc_divider runs W cycles on
//              magnitudes; quotient truncates toward zero, sign=signA^signB; -0->+0.
//    RESULT  : digit->clear, A=d, ENTER_A; op->A=result (with sign), latch op,
//              OP_WAIT; eq ignored.
//    ERR     : err=1, disp_val=0; digit->clear, A=d, ENTER_A; op/eq ignored.
//  - Latency from E: digit/op visible E+1; add/sub/mul result_valid at E+2;
//    div result_valid at E+W+2; ERR for div-by-0 at E+2.
//  - A carries sign only when loaded from a negative result; typed digits are
//    always positive.
//  - result_valid pulses exactly once per RESULT entry (also on the ENTER_A eq).
//  - Reset asserted mid-DIV aborts the divider; no result_valid follows.
// STRUCTURE
//  - calc_defs.vh: state encodings (ENTER_A, OP_WAIT, ENTER_B, COMPUTE, DIV,
//    RESULT, ERR), op codes, MAX_VAL = 10^DIGITS-1.
//  - Sub-module calc_divider: restoring unsigned divider, W-bit; start/done
//    handshake, busy while iterating, same clk/rst.
//  - Top: edge detector, entry datapath, FSM, signed-magnitude result formatter.
// TESTING
//  1. 1,2,+,3,4,= -> disp_val=46, disp_neg=0, result_valid at E+2 of '='.
//  2. 7,-,9,= -> disp_val=2, disp_neg=1; then +,5,= -> disp_val=3, disp_neg=0.
//  3. 1,7,/,5,= -> busy high W cycles, disp_val=3; 5,/,0,= -> err=1, disp_val=0.
//  4. 1,0,0,*,1,0,0,= -> err=1 (10000>9999); next digit 4 -> ENTER_A, disp_val=4.
//  5. 1,2,3,4,5 -> disp_val=1234; key held 50 cycles -> single digit entered;
//     is_num&is_op together -> op taken; num_val=12 -> ignored.
//  6. rst=0 during DIV -> state ENTER_A, all outputs 0 at once, no result_valid.

Source files
------------

// File: rtl/calc_entry_fsm_pkg.sv
// Shared definitions for the calculator entry block.
// Holds the sizing constants, state and operator encodings, the signed-magnitude
// display payload, and the decimal digit-append helper used by the entry datapath.
package calc_entry_fsm_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 14;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
    localparam int unsigned STEP_W  = $clog2(W + 1);
    // Signed evaluation width: holds the full product and the sum of two maximal operands.
    localparam int unsigned RW      = 2 * W + 2;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_OP_WAIT = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DIV     = 3'd4,
        ST_RESULT  = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef struct packed {
        logic         neg;
        logic [W-1:0] mag;
    } smag_t;

    // v*10 + d; callers guarantee the operand stays below 10^DIGITS.
    function automatic logic [W-1:0] dec_append(input logic [W-1:0] v, input logic [3:0] d);
        return v * W'(10) + W'(d);
    endfunction

endpackage

// File: rtl/calc_entry_fsm_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W iterations.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         load operands and begin iterating
//   dividend_i      W-bit dividend
//   divisor_i       W-bit divisor (caller never starts with zero)
//   quotient_o      W-bit quotient, valid when done_o pulses
//   done_o          one-cycle pulse after the last iteration
module calc_entry_fsm_divider
    import calc_entry_fsm_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         done_o
);

    logic [W-1:0]      rem_q;
    logic [W-1:0]      quo_q;
    logic [W-1:0]      dvs_q;
    logic [STEP_W-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [W:0]        trial;
    logic              fits;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    assign trial = {rem_q, quo_q[W-1]};
    assign fits  = trial >= {1'b0, dvs_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dvs_q  <= divisor_i;
                cnt_q  <= STEP_W'(W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= fits ? W'(trial - {1'b0, dvs_q}) : W'(trial);
                quo_q <= {quo_q[W-2:0], fits};
                cnt_q <= cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry FSM: builds operand A, operator and operand B from
// keypad level flags, evaluates A op B in signed decimal and drives the display.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   is_num_i/is_op_i/is_eq_i    key level flags from the scanner
//   num_val_i, op_val_i         digit value / operator code
//   disp_val_o, disp_neg_o      display magnitude and sign
//   err_o                       overflow or divide by zero
//   busy_o                      evaluating; key events are dropped
//   result_valid_o              one-cycle pulse when a result is displayed
//   state_dbg_o                 current state encoding
module calc_entry_fsm
    import calc_entry_fsm_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         is_num_i,
    input  logic         is_op_i,
    input  logic         is_eq_i,
    input  logic [3:0]   num_val_i,
    input  logic [1:0]   op_val_i,
    output logic [W-1:0] disp_val_o,
    output logic         disp_neg_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         result_valid_o,
    output logic [2:0]   state_dbg_o
);

    state_e             state_q, state_d;
    smag_t              a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    smag_t              disp_q, disp_d;
    logic               rv_q, rv_d;
    logic               prev_q, busy_q, err_q;

    logic               key_any, in_busy, key_ev;
    logic               ev_eq, ev_op, ev_num;
    logic               room, b_zero, overflow;
    smag_t              digit_sm, alu_res, div_res;
    logic               div_start, div_done;
    logic [W-1:0]       div_quo;
    logic signed [RW-1:0] a_s, b_s, res_s;
    logic [RW-1:0]      res_mag;

    // Key event = rising edge of any flag; eq beats op beats digit.
    assign key_any  = is_num_i | is_op_i | is_eq_i;
    assign in_busy  = (state_q == ST_COMPUTE) || (state_q == ST_DIV);
    assign key_ev   = key_any & ~prev_q & ~in_busy;
    assign ev_eq    = key_ev & is_eq_i;
    assign ev_op    = key_ev & ~is_eq_i & is_op_i;
    assign ev_num   = key_ev & ~is_eq_i & ~is_op_i & is_num_i & (num_val_i <= 4'd9);
    assign room     = cnt_q < CNT_W'(DIGITS);
    assign b_zero   = (b_q == '0);
    assign digit_sm = {1'b0, W'(num_val_i)};

    // Signed add/sub/mul and signed-magnitude formatting of the result.
    always_comb begin
        a_s = RW'(a_q.mag);
        if (a_q.neg) begin
            a_s = -a_s;
        end
        b_s = RW'(b_q);
        case (op_q)
            OP_SUB:  res_s = a_s - b_s;
            OP_MUL:  res_s = a_s * b_s;
            default: res_s = a_s + b_s;
        endcase
        res_mag  = res_s[RW-1] ? RW'(-res_s) : RW'(res_s);
        overflow = res_mag > RW'(MAX_VAL);
        alu_res  = '{neg: res_s[RW-1], mag: res_mag[W-1:0]};
    end

    // Quotient sign follows A (B is always typed, hence positive); zero is never negative.
    assign div_res = '{neg: a_q.neg & (div_quo != '0), mag: div_quo};

    calc_entry_fsm_divider u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .dividend_i (a_q.mag),
        .divisor_i  (b_q),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A: begin
                if (ev_eq) begin
                    state_d = ST_RESULT;
                end else if (ev_op) begin
                    state_d = ST_OP_WAIT;
                end
            end
            ST_OP_WAIT: begin
                if (ev_num) begin
                    state_d = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (ev_eq) begin
                    state_d = (op_q == OP_DIV) ? ST_DIV : ST_COMPUTE;
                end
            end
            ST_COMPUTE: state_d = overflow ? ST_ERR : ST_RESULT;
            ST_DIV: begin
                if (b_zero) begin
                    state_d = ST_ERR;
                end else if (div_done) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (ev_num) begin
                    state_d = ST_ENTER_A;
                end else if (ev_op) begin
                    state_d = ST_OP_WAIT;
                end
            end
            ST_ERR: begin
                if (ev_num) begin
                    state_d = ST_ENTER_A;
                end
            end
            default: state_d = ST_ENTER_A;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        rv_d      = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_ENTER_A: begin
                if (ev_eq) begin
                    disp_d = a_q;
                    rv_d   = 1'b1;
                end else if (ev_op) begin
                    op_d  = op_e'(op_val_i);
                    cnt_d = '0;
                end else if (ev_num && room) begin
                    a_d    = '{neg: 1'b0, mag: dec_append(a_q.mag, num_val_i)};
                    cnt_d  = cnt_q + CNT_W'(1);
                    disp_d = a_d;
                end
            end
            ST_OP_WAIT: begin
                if (ev_op) begin
                    op_d = op_e'(op_val_i);
                end else if (ev_num) begin
                    b_d    = W'(num_val_i);
                    cnt_d  = CNT_W'(1);
                    disp_d = digit_sm;
                end
            end
            ST_ENTER_B: begin
                if (ev_eq) begin
                    div_start = (op_q == OP_DIV) && !b_zero;
                end else if (ev_num && room) begin
                    b_d    = dec_append(b_q, num_val_i);
                    cnt_d  = cnt_q + CNT_W'(1);
                    disp_d = '{neg: 1'b0, mag: b_d};
                end
            end
            ST_COMPUTE: begin
                if (overflow) begin
                    disp_d = '0;
                end else begin
                    disp_d = alu_res;
                    rv_d   = 1'b1;
                end
            end
            ST_DIV: begin
                if (b_zero) begin
                    disp_d = '0;
                end else if (div_done) begin
                    disp_d = div_res;
                    rv_d   = 1'b1;
                end
            end
            ST_RESULT, ST_ERR: begin
                if (ev_num) begin
                    a_d    = digit_sm;
                    b_d    = '0;
                    op_d   = OP_ADD;
                    cnt_d  = CNT_W'(1);
                    disp_d = digit_sm;
                end else if (ev_op && (state_q == ST_RESULT)) begin
                    a_d   = disp_q;
                    op_d  = op_e'(op_val_i);
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            cnt_q  <= '0;
            disp_q <= '0;
            rv_q   <= 1'b0;
            prev_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            rv_q   <= rv_d;
            prev_q <= key_any;
            busy_q <= (state_d == ST_COMPUTE) || (state_d == ST_DIV);
            err_q  <= (state_d == ST_ERR);
        end
    end

    assign disp_val_o     = disp_q.mag;
    assign disp_neg_o     = disp_q.neg;
    assign err_o          = err_q;
    assign busy_o         = busy_q;
    assign result_valid_o = rv_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: a behavioural calculator model predicts
// each result/error and its arrival cycle; a monitor pops and compares.
module tb_calc_entry_fsm;
    import calc_entry_fsm_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b1;
    logic         is_num_i = 1'b0, is_op_i = 1'b0, is_eq_i = 1'b0;
    logic [3:0]   num_val_i = '0;
    logic [1:0]   op_val_i = '0;
    logic [W-1:0] disp_val_o;
    logic         disp_neg_o, err_o, busy_o, result_valid_o;
    logic [2:0]   state_dbg_o;

    calc_entry_fsm dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .is_num_i       (is_num_i),
        .is_op_i        (is_op_i),
        .is_eq_i        (is_eq_i),
        .num_val_i      (num_val_i),
        .op_val_i       (op_val_i),
        .disp_val_o     (disp_val_o),
        .disp_neg_o     (disp_neg_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .state_dbg_o    (state_dbg_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit is_err;
        int mag;
        bit neg;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;

    // Behavioural calculator: what the user would see on a pocket calculator.
    typedef enum {M_A, M_OPW, M_B, M_RES, M_ERR} mphase_e;
    mphase_e mph;
    int ma, mb, mres, mcnt, mdisp, mop;
    int busy_lo, busy_hi;

    task automatic chk(input string name, input logic signed [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic void model_reset();
        mph = M_A; ma = 0; mb = 0; mres = 0; mcnt = 0; mdisp = 0; mop = 0;
        busy_lo = -10; busy_hi = -10;
        expq.delete();
    endfunction

    function automatic void push_exp(input int due, input bit is_err, input int val);
        expq.push_back(exp_t'{due, is_err, iabs(val), val < 0});
    endfunction

    function automatic void model_num(input int d);
        case (mph)
            M_A: if (mcnt < DIGITS) begin ma = ma * 10 + d; mcnt++; mdisp = ma; end
            M_OPW: begin mb = d; mcnt = 1; mph = M_B; mdisp = d; end
            M_B: if (mcnt < DIGITS) begin mb = mb * 10 + d; mcnt++; mdisp = mb; end
            default: begin ma = d; mb = 0; mop = 0; mcnt = 1; mph = M_A; mdisp = d; end
        endcase
    endfunction

    function automatic void model_op(input int o);
        case (mph)
            M_A: begin mop = o; mcnt = 0; mph = M_OPW; end
            M_OPW: mop = o;
            M_RES: begin ma = mres; mop = o; mcnt = 0; mph = M_OPW; end
            default: ;
        endcase
    endfunction

    function automatic bit model_eq(input int c);
        int r;
        if (mph == M_A) begin
            mres = ma; mph = M_RES; mdisp = ma;
            push_exp(c + 1, 1'b0, ma);
            return 1'b1;
        end
        if (mph != M_B) return 1'b1;
        busy_lo = c + 1;
        if (mop == 3) begin
            if (mb == 0) begin
                busy_hi = c + 1; mph = M_ERR; mdisp = 0; push_exp(c + 2, 1'b1, 0);
            end else begin
                r = ma / mb;
                busy_hi = c + W + 1; mres = r; mph = M_RES; mdisp = r;
                push_exp(c + W + 2, 1'b0, r);
            end
        end else begin
            r = (mop == 0) ? ma + mb : (mop == 1) ? ma - mb : ma * mb;
            busy_hi = c + 1;
            if (iabs(r) > int'(MAX_VAL)) begin
                mph = M_ERR; mdisp = 0; push_exp(c + 2, 1'b1, 0);
            end else begin
                mres = r; mph = M_RES; mdisp = r; push_exp(c + 2, 1'b0, r);
            end
        end
        return 1'b0;
    endfunction

    // One key press: rise, hold for 'hold' cycles, release, idle 'gap' cycles.
    task automatic key(input bit n, input bit o, input bit e, input int v, input int opv,
                       input int hold, input int gap);
        int c;
        bit dropped, chk_disp;
        @(posedge clk); #1;
        is_num_i = n; is_op_i = o; is_eq_i = e;
        num_val_i = 4'(v); op_val_i = 2'(opv);
        c = cyc;
        dropped = (c >= busy_lo) && (c <= busy_hi);
        chk_disp = 1'b1;
        if (!dropped) begin
            if (e) chk_disp = model_eq(c);
            else if (o) model_op(opv);
            else if (n && v <= 9) model_num(v);
        end
        @(posedge clk); @(negedge clk);
        if (!dropped && chk_disp) begin
            chk("disp_val", disp_val_o, iabs(mdisp));
            chk("disp_neg", disp_neg_o, int'(mdisp < 0));
            chk("err", err_o, int'(mph == M_ERR));
        end
        chk("busy", busy_o, int'((c + 1 >= busy_lo) && (c + 1 <= busy_hi)));
        repeat (hold - 1) @(posedge clk);
        #1;
        is_num_i = 1'b0; is_op_i = 1'b0; is_eq_i = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic dig(input int d);
        key(1'b1, 1'b0, 1'b0, d, 0, 1, 1);
    endtask
    task automatic opk(input int o);
        key(1'b0, 1'b1, 1'b0, 0, o, 1, 1);
    endtask
    task automatic eqk();
        key(1'b0, 1'b0, 1'b1, 0, 0, 1, W + 4);
    endtask

    task automatic see(input string name, input int mag, input int neg, input int err);
        @(negedge clk);
        chk({name, "_val"}, disp_val_o, mag);
        chk({name, "_neg"}, disp_neg_o, neg);
        chk({name, "_err"}, err_o, err);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_disp_val", disp_val_o, 0);
        chk("rst_disp_neg", disp_neg_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_state", state_dbg_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Monitor: every result pulse or error entry must match the oldest prediction.
    bit   err_prev = 1'b0;
    exp_t got_e;
    always @(negedge clk) begin
        if (rst_ni && (result_valid_o || (err_o && !err_prev))) begin
            if (expq.size() == 0) begin
                chk("output_without_expectation", expq.size(), 1);
            end else begin
                got_e = expq.pop_front();
                chk("out_cycle", cyc, got_e.due);
                chk("out_is_err", err_o, int'(got_e.is_err));
                chk("out_rv", result_valid_o, int'(!got_e.is_err));
                chk("out_mag", disp_val_o, got_e.mag);
                chk("out_neg", disp_neg_o, int'(got_e.neg));
            end
        end
        err_prev = err_o;
    end

    initial begin
        model_reset();
        do_reset();

        dig(1); dig(2); opk(0); dig(3); dig(4); eqk();
        see("t1", 46, 0, 0);

        dig(7); opk(1); dig(9); eqk();
        see("t2a", 2, 1, 0);
        opk(0); dig(5); eqk();
        see("t2b", 3, 0, 0);

        dig(1); dig(7); opk(3); dig(5); eqk();
        see("t3a", 3, 0, 0);
        dig(5); opk(3); dig(0); eqk();
        see("t3b", 0, 0, 1);

        dig(1); dig(0); dig(0); opk(2); dig(1); dig(0); dig(0); eqk();
        see("t4a", 0, 0, 1);
        dig(4);
        see("t4b", 4, 0, 0);

        do_reset();
        dig(1); dig(2); dig(3); dig(4); dig(5);
        see("t5a", 1234, 0, 0);
        key(1'b0, 1'b1, 1'b0, 0, 0, 50, 1);
        key(1'b1, 1'b1, 1'b0, 3, 1, 1, 1);
        key(1'b1, 1'b0, 1'b0, 12, 0, 1, 1);
        key(1'b1, 1'b0, 1'b0, 6, 0, 50, 1);
        see("t5b", 6, 0, 0);
        eqk();
        see("t5c", 1228, 0, 0);

        dig(1); dig(7); opk(3); dig(5);
        key(1'b0, 1'b0, 1'b1, 0, 0, 1, 3);
        do_reset();
        repeat (W + 6) @(posedge clk);
        see("t6", 0, 0, 0);
        chk("t6_state", state_dbg_o, 0);

        for (int i = 0; i < 400; i++) begin
            int k, hold, gap, v;
            k    = $urandom_range(0, 11);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 2);
            v    = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if (k <= 5)       key(1'b1, 1'b0, 1'b0, v, 0, hold, gap);
            else if (k <= 7)  key(1'b0, 1'b1, 1'b0, 0, $urandom_range(0, 3), hold, gap);
            else if (k <= 9)  key(1'b0, 1'b0, 1'b1, 0, 0, hold, gap);
            else if (k == 10) key(1'b1, 1'b1, 1'b0, v, $urandom_range(0, 3), hold, gap);
            else              key(1'b1, 1'($urandom_range(0, 1)), 1'b1, v, $urandom_range(0, 3), hold, gap);
        end

        for (int t = 0; t < 60 && expq.size() != 0; t++) @(negedge clk);
        chk("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
